instruction_decode_stage: RTL

- Second pipeline stage. Consumes the fetched instruction word and PC+1 from the fetch stage.
- Reads the integrated 32-entry register file, decodes control signals and computes the branch/jump target.
- Registers everything into the ID/EX pipeline register for execute.
- Also detects load-use hazards (stall), accepts flushes, writes back results and enters a sticky HALT state.

---
 rtl/instruction_decode_stage.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/instruction_decode_stage.sv
// Decode stage: register file with write-through bypass, control decode,
// branch target, load-use stall, flush, and a sticky HALT state.
module instruction_decode_stage #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int RA_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       ir_in,
  input  logic [31:0]       pc_in,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [RA_W-1:0]   wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] rs1_val,
  output logic [DATA_W-1:0] rs2_val,
  output logic [31:0]       imm_ext,
  output logic [RA_W-1:0]   rd,
  output logic [3:0]        alu_op,
  output logic              alu_src_imm,
  output logic              reg_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic [1:0]        is_branch,
  output logic              is_jump,
  output logic [31:0]       target,
  output logic              valid_out,
  output logic              illegal,
  output logic              stall_out,
  output logic              halted
);

  typedef enum logic {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_regs [NREGS];

  logic [5:0]        w_op;
  logic [RA_W-1:0]   w_rd;
  logic [RA_W-1:0]   w_rs1;
  logic [RA_W-1:0]   w_rs2;
  logic [15:0]       w_imm16;
  logic [31:0]       w_imm_ext;
  logic [31:0]       w_target;
  logic [DATA_W-1:0] w_rs1_val;
  logic [DATA_W-1:0] w_rs2_val;

  logic [3:0]        w_alu_op;
  logic              w_alu_src_imm;
  logic              w_rtype;
  logic              w_wr_rd;
  logic              w_mem_read;
  logic              w_mem_write;
  logic [1:0]        w_is_branch;
  logic              w_is_jump;
  logic              w_zext;
  logic              w_legal;
  logic              w_is_halt;
  logic              w_uses_rs2;
  logic              w_hazard;
  logic              w_run_issue;
  logic              w_load_instr;

  assign w_op    = ir_in[31:26];
  assign w_rd    = ir_in[25:21];
  assign w_rs1   = ir_in[20:16];
  assign w_rs2   = ir_in[15:11];
  assign w_imm16 = ir_in[15:0];

  always_comb begin
    w_alu_op      = 4'd0;
    w_alu_src_imm = 1'b0;
    w_rtype       = 1'b0;
    w_wr_rd       = 1'b0;
    w_mem_read    = 1'b0;
    w_mem_write   = 1'b0;
    w_is_branch   = 2'b00;
    w_is_jump     = 1'b0;
    w_zext        = 1'b0;
    w_legal       = 1'b1;
    w_is_halt     = 1'b0;
    case (w_op)
      6'h00: w_legal = 1'b1;
      6'h01: begin w_rtype = 1'b1; w_alu_op = 4'd0; end
      6'h02: begin w_rtype = 1'b1; w_alu_op = 4'd1; end
      6'h03: begin w_rtype = 1'b1; w_alu_op = 4'd2; end
      6'h04: begin w_rtype = 1'b1; w_alu_op = 4'd3; end
      6'h05: begin w_rtype = 1'b1; w_alu_op = 4'd4; end
      6'h06: begin w_rtype = 1'b1; w_alu_op = 4'd5; end
      6'h07: begin w_rtype = 1'b1; w_alu_op = 4'd6; end
      6'h08: begin w_rtype = 1'b1; w_alu_op = 4'd7; end
      6'h10: begin w_wr_rd = 1'b1; w_alu_src_imm = 1'b1; w_alu_op = 4'd0; end
      6'h11: begin w_wr_rd = 1'b1; w_alu_src_imm = 1'b1; w_alu_op = 4'd2; w_zext = 1'b1; end
      6'h12: begin w_wr_rd = 1'b1; w_alu_src_imm = 1'b1; w_alu_op = 4'd3; w_zext = 1'b1; end
      6'h20: begin w_wr_rd = 1'b1; w_alu_src_imm = 1'b1; w_mem_read = 1'b1; end
      6'h21: begin w_alu_src_imm = 1'b1; w_mem_write = 1'b1; end
      6'h30: begin w_alu_op = 4'd1; w_is_branch = 2'b01; end
      6'h31: begin w_alu_op = 4'd1; w_is_branch = 2'b10; end
      6'h38: w_is_jump = 1'b1;
      6'h3F: w_is_halt = 1'b1;
      default: w_legal = 1'b0;
    endcase
  end

  // rs2 is a real source only for R-type, store data and branch compares
  assign w_uses_rs2 = w_rtype | w_mem_write | (w_is_branch != 2'b00);
  assign w_imm_ext  = w_zext ? {16'h0000, w_imm16} : {{16{w_imm16[15]}}, w_imm16};
  assign w_target   = pc_in + w_imm_ext;

  always_comb begin
    if (w_rs1 == '0) begin
      w_rs1_val = '0;
    end else if (wb_en && (wb_addr == w_rs1)) begin
      w_rs1_val = wb_data;
    end else begin
      w_rs1_val = r_regs[w_rs1];
    end
  end

  always_comb begin
    if (w_rs2 == '0) begin
      w_rs2_val = '0;
    end else if (wb_en && (wb_addr == w_rs2)) begin
      w_rs2_val = wb_data;
    end else begin
      w_rs2_val = r_regs[w_rs2];
    end
  end

  assign w_hazard = valid_out & mem_read & (rd != '0) &
                    ((rd == w_rs1) | (w_uses_rs2 & (rd == w_rs2)));

  assign w_run_issue  = (r_state == ST_RUN) & ~flush & ~w_hazard;
  assign w_load_instr = w_run_issue & w_legal & ~w_is_halt;

  always_comb begin
    if (reset) begin
      stall_out = 1'b0;
    end else if (r_state == ST_HALTED) begin
      stall_out = 1'b1;
    end else if (flush) begin
      stall_out = 1'b0;
    end else begin
      stall_out = w_hazard;
    end
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (wb_en && (wb_addr != '0)) begin
      r_regs[wb_addr] <= wb_data;
    end
  end

  // ID/EX register and HALT state; anything not issued becomes a bubble
  always_ff @(negedge clk) begin
    if (reset) begin
      r_state     <= ST_RUN;
      halted      <= 1'b0;
      rs1_val     <= '0;
      rs2_val     <= '0;
      imm_ext     <= 32'h0;
      rd          <= '0;
      alu_op      <= 4'd0;
      alu_src_imm <= 1'b0;
      reg_write   <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      is_branch   <= 2'b00;
      is_jump     <= 1'b0;
      target      <= 32'h0;
      valid_out   <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      if (w_run_issue && w_is_halt) begin
        r_state <= ST_HALTED;
        halted  <= 1'b1;
      end
      if (w_load_instr) begin
        rs1_val     <= w_rs1_val;
        rs2_val     <= w_rs2_val;
        imm_ext     <= w_imm_ext;
        rd          <= w_rd;
        alu_op      <= w_alu_op;
        alu_src_imm <= w_alu_src_imm;
        reg_write   <= (w_wr_rd | w_rtype) & (w_rd != '0);
        mem_read    <= w_mem_read;
        mem_write   <= w_mem_write;
        is_branch   <= w_is_branch;
        is_jump     <= w_is_jump;
        target      <= w_target;
        valid_out   <= 1'b1;
        illegal     <= 1'b0;
      end else begin
        rs1_val     <= '0;
        rs2_val     <= '0;
        imm_ext     <= 32'h0;
        rd          <= '0;
        alu_op      <= 4'd0;
        alu_src_imm <= 1'b0;
        reg_write   <= 1'b0;
        mem_read    <= 1'b0;
        mem_write   <= 1'b0;
        is_branch   <= 2'b00;
        is_jump     <= 1'b0;
        target      <= 32'h0;
        valid_out   <= 1'b0;
        illegal     <= w_run_issue & ~w_legal;
      end
    end
  end

endmodule
